// File: rtl/iter_mul_div.sv
// Iterative multiply/divide unit for the multicycle MIPS core: MULT/MULTU/DIV/DIVU in WIDTH+1
// cycles via shift-add and restoring division on magnitudes, plus single-cycle MTHI/MTLO.
module iter_mul_div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] work;       // product accumulator, or {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opB;
    logic [WIDTH-1:0]   origA;
    logic [CNT_W-1:0]   counter;
    logic               signQ;
    logic               signR;
    logic               isDiv;
    logic               divZero;

    logic               isSigned;
    logic               isDivOp;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divDiff;
    logic               lastIter;

    assign isSigned = (op == OP_MULT) || (op == OP_DIV);
    assign isDivOp  = (op == OP_DIV) || (op == OP_DIVU);
    assign absA     = (isSigned && a[WIDTH-1]) ? -a : a;
    assign absB     = (isSigned && b[WIDTH-1]) ? -b : b;

    // Multiplier bits leave through work[0]; partial sums enter from the top with their carry.
    assign mulSum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opB} : '0);
    assign divShift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    assign divDiff  = divShift - {1'b0, opB};
    assign lastIter = (counter == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            work        <= '0;
            opB         <= '0;
            origA       <= '0;
            counter     <= '0;
            signQ       <= 1'b0;
            signR       <= 1'b0;
            isDiv       <= 1'b0;
            divZero     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                work        <= {{WIDTH{1'b0}}, absA};
                                opB         <= absB;
                                origA       <= a;
                                signQ       <= isSigned & (a[WIDTH-1] ^ b[WIDTH-1]);
                                signR       <= isSigned & a[WIDTH-1];
                                isDiv       <= isDivOp;
                                divZero     <= isDivOp && (b == '0);
                                counter     <= '0;
                                busy        <= 1'b1;
                                div_by_zero <= 1'b0;
                                state       <= isDivOp ? DIV : MUL;
                            end
                            OP_MTHI: begin
                                hi          <= a;
                                div_by_zero <= 1'b0;
                            end
                            OP_MTLO: begin
                                lo          <= a;
                                div_by_zero <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    work    <= {mulSum, work[WIDTH-1:1]};
                    counter <= counter + CNT_W'(1);
                    if (lastIter) state <= FIX;
                end
                DIV: begin
                    // Restoring step: keep the trial difference only when it did not borrow.
                    if (!divDiff[WIDTH])
                        work <= {divDiff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
                    else
                        work <= {divShift[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
                    counter <= counter + CNT_W'(1);
                    if (lastIter) state <= FIX;
                end
                FIX: begin
                    if (!isDiv) begin
                        {hi, lo} <= signQ ? -work : work;
                    end else if (divZero) begin
                        hi          <= origA;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        hi <= signR ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
                        lo <= signQ ? -work[WIDTH-1:0] : work[WIDTH-1:0];
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_mul_div.sv
// Randomized and directed bench for iter_mul_div against a plain-arithmetic HI/LO reference model.
module tb_iter_mul_div;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic         dbz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int           nCompared = 0;
    int           nMismatched = 0;
    logic [W-1:0] expHi = '0;
    logic [W-1:0] expLo = '0;

    always #5 clk = ~clk;

    iter_mul_div #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // MIPS HI/LO semantics from ordinary 64-bit arithmetic (truncating division).
    function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
        longint          sx, sy, q, r;
        longint unsigned ux, uy, uq, ur;
        logic [63:0]     p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        z = 1'b0;
        h = '0;
        l = '0;
        case (o)
            3'd0: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
            3'd1: begin p = ux * uy; h = p[63:32]; l = p[31:0]; end
            default: begin
                if (y == '0) begin
                    h = x; l = '1; z = 1'b1;
                end else if (o == 3'd2) begin
                    q = sx / sy; r = sx % sy;
                    p = q; l = p[31:0];
                    p = r; h = p[31:0];
                end else begin
                    uq = ux / uy; ur = ux % uy;
                    p = uq; l = p[31:0];
                    p = ur; h = p[31:0];
                end
            end
        endcase
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic runOp(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] eh, el;
        logic         ez;
        int           n;
        model(o, x, y, eh, el, ez);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
        chk("accept_busy", 64'(busy), 64'd1);
        chk("accept_done", 64'(done), 64'd0);
        chk("accept_dbz", 64'(dbz), 64'd0);
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == W / 2) begin
                chk("hold_hi", 64'(hi), 64'(expHi));
                chk("hold_lo", 64'(lo), 64'(expLo));
            end
        end
        chk("latency", 64'(n), 64'(W + 1));
        chk("done", 64'(done), 64'd1);
        chk("hi", 64'(hi), 64'(eh));
        chk("lo", 64'(lo), 64'(el));
        chk("dbz", 64'(dbz), 64'(ez));
        expHi = eh;
        expLo = el;
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d cycles=%0d", o, x, y, hi, lo, dbz, n);
    endtask

    task automatic mtOp(input logic toHi, input logic [W-1:0] x);
        op = toHi ? 3'b100 : 3'b101; a = x; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (toHi) expHi = x; else expLo = x;
        chk("mt_hi", 64'(hi), 64'(expHi));
        chk("mt_lo", 64'(lo), 64'(expLo));
        chk("mt_busy", 64'(busy), 64'd0);
        chk("mt_done", 64'(done), 64'd0);
        $display("op=%0d a=%h -> hi=%h lo=%h", toHi ? 4 : 5, x, hi, lo);
    endtask

    task automatic reservedOp(input logic [2:0] o);
        op = o; a = $urandom; b = $urandom; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("rsv_busy", 64'(busy), 64'd0);
        chk("rsv_hi", 64'(hi), 64'(expHi));
        chk("rsv_lo", 64'(lo), 64'(expLo));
        $display("op=%0d reserved -> hi=%h lo=%h busy=%0d", o, hi, lo, busy);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dbz", 64'(dbz), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        runOp(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        runOp(3'd0, 32'hFFFFFFFD, 32'h5);
        runOp(3'd0, 32'h80000000, 32'h80000000);
        runOp(3'd2, 32'hFFFFFFF9, 32'h2);
        runOp(3'd3, 32'h7, 32'h2);
        runOp(3'd2, 32'h80000000, 32'hFFFFFFFF);
        runOp(3'd3, 32'h12345678, 32'h0);

        // MULTU 3*4 with an MTHI attempt while busy.
        op = 3'd1; a = 32'd3; b = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t5_dbz_cleared", 64'(dbz), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        op = 3'b100; a = 32'hAA; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 5;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_latency", 64'(n), 64'(W + 1));
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_hi", 64'(hi), 64'd0);
        chk("t5_lo", 64'(lo), 64'hC);
        expHi = '0;
        expLo = 32'hC;
        $display("op=1 a=00000003 b=00000004 with MTHI while busy -> hi=%h lo=%h", hi, lo);
        @(posedge clk); #1;
        chk("t5_done_drop", 64'(done), 64'd0);
        mtOp(1'b0, 32'h55);
        reservedOp(3'b110);
        reservedOp(3'b111);

        // Reset in the middle of a DIV.
        op = 3'd2; a = $urandom; b = $urandom | 32'h1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        chk("t6_hi", 64'(hi), 64'd0);
        chk("t6_lo", 64'(lo), 64'd0);
        $display("reset mid-DIV -> busy=%0d hi=%h lo=%h", busy, hi, lo);
        expHi = '0;
        expLo = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        runOp(3'd3, 32'd100, 32'd7);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 9))
                0: mtOp(1'($urandom_range(0, 1)), $urandom);
                1: reservedOp(3'($urandom_range(6, 7)));
                default: runOp(3'($urandom_range(0, 3)), pick(), pick());
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
